// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags. Illegal writes on full and
// reads on empty are refused and flagged, leaving the FIFO state unchanged.
module fifo_sync_param #(
    parameter int unsigned ENTRIES  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AF_LEVEL = ENTRIES - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_write_ctrl,
    input  logic [DATA_W-1:0]         in_write_data,
    input  logic                      in_read_ctrl,
    input  logic                      in_clear_err,
    output logic [DATA_W-1:0]         out_read_data,
    output logic                      out_read_valid,
    output logic                      out_is_empty,
    output logic                      out_is_full,
    output logic [$clog2(ENTRIES):0]  out_count,
    output logic                      out_almost_full,
    output logic                      out_almost_empty,
    output logic                      out_overflow,
    output logic                      out_underflow
);

    localparam int unsigned COUNT_W = $clog2(ENTRIES) + 1;
    localparam int unsigned PTR_W   = $clog2(ENTRIES);

    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(ENTRIES);
    localparam logic [COUNT_W-1:0] AF_CNT   = COUNT_W'(AF_LEVEL);
    localparam logic [COUNT_W-1:0] AE_CNT   = COUNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(ENTRIES - 1);

    logic [DATA_W-1:0]  mem [ENTRIES];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic [COUNT_W-1:0] count;
    logic               rd_ok;
    logic               wr_ok;

    // Accept decisions; a write on full is only legal alongside an accepted read.
    always_comb begin
        rd_ok = in_read_ctrl && (count != '0);
        wr_ok = in_write_ctrl && ((count != FULL_CNT) || rd_ok);
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wp] <= in_write_data;
        end
    end

    // Pointers, occupancy, read data and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            out_read_data  <= '0;
            out_read_valid <= 1'b0;
            out_overflow   <= 1'b0;
            out_underflow  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= (wp == PTR_LAST) ? '0 : wp + PTR_W'(1);
            end
            if (rd_ok) begin
                out_read_data <= mem[rp];
                rp            <= (rp == PTR_LAST) ? '0 : rp + PTR_W'(1);
            end
            out_read_valid <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
            // A new error event wins over a simultaneous clear.
            if (in_write_ctrl && !wr_ok) begin
                out_overflow <= 1'b1;
            end else if (in_clear_err) begin
                out_overflow <= 1'b0;
            end
            if (in_read_ctrl && !rd_ok) begin
                out_underflow <= 1'b1;
            end else if (in_clear_err) begin
                out_underflow <= 1'b0;
            end
        end
    end

    // Status decoded purely from the registered count.
    always_comb begin
        out_count        = count;
        out_is_empty     = (count == '0);
        out_is_full      = (count == FULL_CNT);
        out_almost_full  = (count >= AF_CNT);
        out_almost_empty = (count <= AE_CNT);
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a vector table drives the default 4-entry FIFO through
// fill/drain, overflow, underflow and pass-through; a hand-written sequence
// covers reset mid-operation; a 5-entry instance streams random traffic
// against a scoreboard.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // 4-entry instance (default thresholds AF=3, AE=1)
    logic       w4 = 0, r4 = 0, c4 = 0;
    logic [7:0] wd4 = 0, rd4;
    logic       v4, e4, f4, af4, ae4, ov4, un4;
    logic [2:0] cnt4;

    fifo_sync_param u_dut4 (
        .clk(clk), .rst(rst),
        .in_write_ctrl(w4), .in_write_data(wd4), .in_read_ctrl(r4), .in_clear_err(c4),
        .out_read_data(rd4), .out_read_valid(v4), .out_is_empty(e4), .out_is_full(f4),
        .out_count(cnt4), .out_almost_full(af4), .out_almost_empty(ae4),
        .out_overflow(ov4), .out_underflow(un4)
    );

    // 5-entry instance, AF=4, AE=1
    logic       w5 = 0, r5 = 0, c5 = 0;
    logic [7:0] wd5 = 0, rd5;
    logic       v5, e5, f5, af5, ae5, ov5, un5;
    logic [3:0] cnt5;

    fifo_sync_param #(.ENTRIES(5), .DATA_W(8), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_write_ctrl(w5), .in_write_data(wd5), .in_read_ctrl(r5), .in_clear_err(c5),
        .out_read_data(rd5), .out_read_valid(v5), .out_is_empty(e5), .out_is_full(f5),
        .out_count(cnt5), .out_almost_full(af5), .out_almost_empty(ae5),
        .out_overflow(ov5), .out_underflow(un5)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full status check of the 4-entry instance against an expected count and flags.
    task automatic chk4(input string tag, input int cnt, input logic vld, input logic [7:0] dat,
                        input logic ovf, input logic unf);
        chk({tag, ".count"}, int'(cnt4), cnt);
        chk({tag, ".empty"}, int'(e4), int'(cnt == 0));
        chk({tag, ".full"}, int'(f4), int'(cnt == 4));
        chk({tag, ".afull"}, int'(af4), int'(cnt >= 3));
        chk({tag, ".aempty"}, int'(ae4), int'(cnt <= 1));
        chk({tag, ".valid"}, int'(v4), int'(vld));
        chk({tag, ".data"}, int'(rd4), int'(dat));
        chk({tag, ".ovf"}, int'(ov4), int'(ovf));
        chk({tag, ".unf"}, int'(un4), int'(unf));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[25];

    logic [7:0] exp_q[$];
    logic [7:0] model[$];

    initial begin
        // wr, wd, rd, clr -> count, valid, data, ovf, unf (all after the edge)
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h44, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1, 1'b0, 8'h44, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 8'h66, 1'b1, 1'b0, 4, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h02, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h03, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h04, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h66, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 8'h77, 1'b0, 1'b0, 1, 1'b0, 8'h66, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 8'h88, 1'b1, 1'b0, 1, 1'b1, 8'h77, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h88, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        chk4("reset4", 0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset5.count", int'(cnt5), 0);
        chk("reset5.aempty", int'(ae5), 1);
        chk("reset5.afull", int'(af5), 0);
        rst = 1'b0;
        step();
        chk4("idle4", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 25; i++) begin
            w4 = tbl[i].wr; wd4 = tbl[i].wd; r4 = tbl[i].rd; c4 = tbl[i].clr;
            step();
            chk4($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].dat,
                 tbl[i].ovf, tbl[i].unf);
        end
        w4 = 0; r4 = 0; c4 = 0;

        // Reset mid-operation: count 3 with overflow set, rst with rd+wr
        for (int i = 1; i <= 4; i++) begin
            w4 = 1'b1; wd4 = 8'(i);
            step();
        end
        wd4 = 8'hEE;
        step();
        chk4("pre_rst_ovf", 4, 1'b0, 8'h88, 1'b1, 1'b0);
        w4 = 1'b0; r4 = 1'b1;
        step();
        chk4("pre_rst_rd", 3, 1'b1, 8'h01, 1'b1, 1'b0);
        rst = 1'b1; w4 = 1'b1; wd4 = 8'h99; r4 = 1'b1;
        step();
        chk4("mid_rst", 0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0; w4 = 1'b0; r4 = 1'b0;
        step();
        chk4("post_rst", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Random stream through the 5-entry instance with scoreboard
        begin
            int  sent;
            int  cyc;
            logic last_rd;
            sent = 0;
            cyc = 0;
            last_rd = 1'b0;
            while ((sent < 12 || model.size() != 0) && cyc < 400) begin
                logic do_rd, do_wr;
                do_rd = (model.size() != 0) && ($urandom_range(0, 1) == 1);
                do_wr = (sent < 12) && ((model.size() != 5) || do_rd) &&
                        ($urandom_range(0, 2) != 0);
                w5 = do_wr; r5 = do_rd;
                wd5 = 8'(8'hC0 + sent);
                if (do_rd) exp_q.push_back(model.pop_front());
                if (do_wr) begin
                    model.push_back(wd5);
                    sent++;
                end
                last_rd = do_rd;
                step();
                cyc++;
                chk("s5.count", int'(cnt5), model.size());
                chk("s5.afull", int'(af5), int'(model.size() >= 4));
                chk("s5.aempty", int'(ae5), int'(model.size() <= 1));
                chk("s5.full", int'(f5), int'(model.size() == 5));
                chk("s5.empty", int'(e5), int'(model.size() == 0));
                chk("s5.err", int'({ov5, un5}), 0);
                chk("s5.valid", int'(v5), int'(last_rd));
                if (v5) begin
                    if (exp_q.size() == 0) begin
                        chk("s5.unexpected_pop", 1, 0);
                    end else begin
                        chk("s5.data", int'(rd5), int'(exp_q.pop_front()));
                    end
                end
            end
            w5 = 0; r5 = 0;
            chk("s5.timeout", int'(cyc < 400), 1);
            chk("s5.all_sent", sent, 12);
            chk("s5.sb_drained", exp_q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO with full storage, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the successor to our flag-only FIFO control: it stores data of configurable width and depth, and tolerates illegal writes on full and reads on empty instead of requiring the environment to avoid them. It sits between a single producer and a single consumer in one clock domain. Formal property checks and the directed bench both bind to it.

## Interface
- ENTRIES, 4, FIFO depth; any integer >= 2, power of two not required.
- DATA_W, 8, data width in bits, >= 1.
- AF_LEVEL, ENTRIES-1, almost-full threshold, 1..ENTRIES.
- AE_LEVEL, 1, almost-empty threshold, 0..ENTRIES-1.
- Derived: COUNT_W = $clog2(ENTRIES)+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_write_ctrl  in  1  write request.
- in_write_data  in  DATA_W  write data, sampled with in_write_ctrl.
- in_read_ctrl  in  1  read request.
- in_clear_err  in  1  clears sticky error flags.
- out_read_data  out  DATA_W  registered read data.
- out_read_valid  out  1  out_read_data holds a newly popped word this cycle.
- out_is_empty  out  1  count == 0.
- out_is_full  out  1  count == ENTRIES.
- out_count  out  COUNT_W  current occupancy, 0..ENTRIES.
- out_almost_full  out  1  count >= AF_LEVEL.
- out_almost_empty  out  1  count <= AE_LEVEL.
- out_overflow  out  1  sticky: a write was dropped.
- out_underflow  out  1  sticky: a read was refused.

## Operation
- Storage: ENTRIES x DATA_W array, write pointer wp, read pointer rp, each 0..ENTRIES-1. Both wrap from ENTRIES-1 to 0 by explicit compare, not by bit truncation.
- A read is accepted when rd_ok = in_read_ctrl && count != 0.
- A write is accepted when wr_ok = in_write_ctrl && (count != ENTRIES || rd_ok). A write on full is accepted only if a read is accepted in the same cycle.
- Read on empty is refused, including when a write occurs in the same cycle. There is no fall-through. The write is still accepted.
- Count update: count + wr_ok - rd_ok. Count never exceeds ENTRIES and never goes below 0.
- Accepted write: mem[wp] <= in_write_data, then wp advances.
- Accepted read: out_read_data <= mem[rp], then rp advances, and out_read_valid = 1 the next cycle.
- When no read is accepted, out_read_data holds its value and out_read_valid = 0.
- Status outputs are decoded only from the registered count, with no combinational path from the inputs: out_is_empty, out_is_full, out_count, out_almost_full, out_almost_empty.
- Errors:
  - out_overflow is set on in_write_ctrl && !wr_ok.
  - out_underflow is set on in_read_ctrl && !rd_ok.
  - Flags stay set until in_clear_err or rst.
  - If in_clear_err coincides with a new error event, the set wins and the flag stays 1.
- FIFO state is unaffected by errors: refused operations change no pointer, count or memory.

## Timing
- Reset, synchronous on rising clk with rst = 1:
  - wp = rp = 0, count = 0.
  - out_is_empty = 1, out_almost_empty = 1, out_is_full = 0, out_almost_full = 0 (AF_LEVEL >= 1).
  - out_overflow = out_underflow = 0, out_read_valid = 0, out_read_data = 0.
  - Memory contents are not reset.
- rst overrides all simultaneous requests. A reset mid-operation discards all contents; the first cycle after rst deasserts is the empty state.
- Write to status latency is 1 cycle: a write accepted at edge N is reflected in out_count after edge N.
- Read latency is 1 cycle: the request is sampled at edge N, and out_read_data/out_read_valid are valid after edge N.
- Minimum write-to-read latency is 2 cycles: write at N, read request at N+1, data after N+1.
- Simultaneous accepted read and write: count unchanged, both pointers advance. At count == 1 the read returns the old word, never the word being written.
- Sustained throughput is one write and one read per cycle at any occupancy except refused cases.

## Test plan
- Fill/drain (ENTRIES=4, DATA_W=8): after reset, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> out_count 1,2,3,4; out_is_full=1 after the 4th. Then read 4 -> out_read_data 0x11..0x44 in order with out_read_valid=1; out_is_empty=1 after the last read.
- Overflow: at full, write 0x55 alone -> out_overflow=1, count stays 4, later reads never return 0x55. Pulse in_clear_err -> out_overflow=0 the next cycle.
- Underflow with write: when empty, assert read and write 0xA5 in the same cycle -> out_underflow=1, out_read_valid=0, count=1. The next read returns 0xA5.
- Full pass-through: at full, simultaneous read and write of 0x66 -> out_overflow=0, count stays 4, and 0x66 is returned as the 4th subsequent read.
- Wrap-around with ENTRIES=5, AF_LEVEL=4, AE_LEVEL=1: stream 12 words with random interleaving -> in-order data and no errors. out_almost_full=1 exactly at count >= 4; out_almost_empty=1 exactly at count <= 1.
- Reset mid-operation: at count=3 with out_overflow=1, assert rst together with read and write requests -> next cycle count=0, out_is_empty=1, errors 0, out_read_valid=0, out_read_data=0.
